usb_tx_scheduler: RTL and testbench

Sequencer and arbiter in front of the USB TX packet loader/serializer. It takes whole-packet requests from two sources: a handshake/token packet builder and a data packet builder. It grants one at a time, presents the selected 544-bit packet, and drives the loader's copy strobe, load-complete qualifier and bit-rate strobe. It watches the loader's completion flag, enforces an inter-packet idle gap and aborts stalled transmissions on timeout.

---
 rtl/usb_tx_scheduler.sv | 155 +++++++++++++++
 tb/tb_usb_tx_scheduler.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_scheduler.sv
// usb_tx_scheduler
//   Arbitrates whole-packet requests from the handshake/token builder and the
//   data builder, hands the granted 544-bit packet to the TX loader, generates
//   the loader's copy strobe, load-complete qualifier and bit-rate strobe, then
//   waits for completion (or aborts on timeout) and holds an idle gap.
//
// Ports
//   clk, n_rst              system clock, synchronous active-low reset
//   req_hs / pkt_hs         handshake request (held until done_hs) and packet
//   req_data / pkt_data     data request (held until done_data) and packet
//   complete_TX             loader reports packet + EOP finished
//   grant_hs / grant_data   1-cycle pulse when the packet is latched
//   done_hs / done_data     1-cycle pulse at end of transmission
//   tx_err                  with done_*, packet aborted on timeout
//   busy                    scheduler not idle
//   packet_TX               latched packet to the loader
//   copy_signal             loader load strobe
//   packet_load_complete_TX loader enable; low holds the line at J
//   bit_en_TX               bit-rate strobe
//   packet_counter          bit_en_TX pulses issued for the current packet
module usb_tx_scheduler #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned GAP_BITS     = 2,
  parameter int unsigned TIMEOUT_BITS = 600,
  parameter int unsigned HS_BURST_MAX = 2
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         req_hs,
  input  logic [543:0] pkt_hs,
  input  logic         req_data,
  input  logic [543:0] pkt_data,
  input  logic         complete_TX,
  output logic         grant_hs,
  output logic         grant_data,
  output logic         done_hs,
  output logic         done_data,
  output logic         tx_err,
  output logic         busy,
  output logic [543:0] packet_TX,
  output logic         copy_signal,
  output logic         packet_load_complete_TX,
  output logic         bit_en_TX,
  output logic [9:0]   packet_counter
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  localparam logic [7:0]  LP_BIT_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [11:0] LP_GAP_LAST = 12'(GAP_BITS * CLKS_PER_BIT - 1);
  localparam logic [9:0]  LP_TIMEOUT  = 10'(TIMEOUT_BITS);
  localparam logic [7:0]  LP_HS_MAX   = 8'(HS_BURST_MAX);

  state_t      r_state;
  logic [7:0]  r_timer;
  logic [11:0] r_gap_cnt;
  logic [7:0]  r_burst;
  logic        r_owner_data;
  logic        w_pick_data;

  // Data only pre-empts the handshake source once the hs burst is exhausted.
  assign w_pick_data = req_data && (!req_hs || (r_burst == LP_HS_MAX));
  assign busy        = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state                 <= IDLE;
      r_timer                 <= '0;
      r_gap_cnt               <= '0;
      r_burst                 <= '0;
      r_owner_data            <= 1'b0;
      grant_hs                <= 1'b0;
      grant_data              <= 1'b0;
      done_hs                 <= 1'b0;
      done_data               <= 1'b0;
      tx_err                  <= 1'b0;
      packet_TX               <= '0;
      copy_signal             <= 1'b0;
      packet_load_complete_TX <= 1'b0;
      bit_en_TX               <= 1'b0;
      packet_counter          <= '0;
    end else begin
      grant_hs    <= 1'b0;
      grant_data  <= 1'b0;
      done_hs     <= 1'b0;
      done_data   <= 1'b0;
      tx_err      <= 1'b0;
      copy_signal <= 1'b0;
      bit_en_TX   <= 1'b0;

      case (r_state)
        IDLE: begin
          if (req_hs || req_data) begin
            r_state                 <= LOAD;
            copy_signal             <= 1'b1;
            packet_load_complete_TX <= 1'b0;
            r_timer                 <= '0;
            packet_counter          <= '0;
            r_owner_data            <= w_pick_data;
            if (w_pick_data) begin
              packet_TX  <= pkt_data;
              grant_data <= 1'b1;
            end else begin
              packet_TX  <= pkt_hs;
              grant_hs   <= 1'b1;
            end
          end
        end

        LOAD: begin
          r_state                 <= SHIFT;
          packet_load_complete_TX <= 1'b1;
          r_timer                 <= '0;
          if (r_owner_data) begin
            r_burst <= '0;
          end else if (r_burst != LP_HS_MAX) begin
            r_burst <= r_burst + 8'd1;
          end
        end

        SHIFT: begin
          // Completion takes priority over a simultaneous timeout.
          if (complete_TX || (packet_counter >= LP_TIMEOUT)) begin
            r_state                 <= GAP;
            r_gap_cnt               <= '0;
            packet_load_complete_TX <= 1'b0;
            done_hs                 <= !r_owner_data;
            done_data               <= r_owner_data;
            tx_err                  <= !complete_TX;
          end else if (r_timer == LP_BIT_LAST) begin
            // Strobe is registered: it lands one bit time after the count starts.
            r_timer   <= '0;
            bit_en_TX <= 1'b1;
            if (packet_counter != '1) begin
              packet_counter <= packet_counter + 10'd1;
            end
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end

        GAP: begin
          if (r_gap_cnt == LP_GAP_LAST) begin
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 12'd1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_scheduler.sv
module tb_usb_tx_scheduler;

  localparam int unsigned CPB   = 8;
  localparam int unsigned GAPB  = 2;
  localparam int unsigned TMO   = 600;
  localparam int unsigned HSMAX = 2;

  logic         clk;
  logic         n_rst;
  logic         req_hs;
  logic [543:0] pkt_hs;
  logic         req_data;
  logic [543:0] pkt_data;
  logic         complete_TX;
  logic         grant_hs;
  logic         grant_data;
  logic         done_hs;
  logic         done_data;
  logic         tx_err;
  logic         busy;
  logic [543:0] packet_TX;
  logic         copy_signal;
  logic         packet_load_complete_TX;
  logic         bit_en_TX;
  logic [9:0]   packet_counter;

  usb_tx_scheduler #(
    .CLKS_PER_BIT(CPB),
    .GAP_BITS(GAPB),
    .TIMEOUT_BITS(TMO),
    .HS_BURST_MAX(HSMAX)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .req_hs(req_hs),
    .pkt_hs(pkt_hs),
    .req_data(req_data),
    .pkt_data(pkt_data),
    .complete_TX(complete_TX),
    .grant_hs(grant_hs),
    .grant_data(grant_data),
    .done_hs(done_hs),
    .done_data(done_data),
    .tx_err(tx_err),
    .busy(busy),
    .packet_TX(packet_TX),
    .copy_signal(copy_signal),
    .packet_load_complete_TX(packet_load_complete_TX),
    .bit_en_TX(bit_en_TX),
    .packet_counter(packet_counter)
  );

  typedef struct {
    bit           is_done;
    bit           is_data;
    logic [543:0] pkt;
    bit           err;
    int           cnt;
  } exp_t;

  exp_t         exp_q[$];
  logic [543:0] hs_q[$];
  logic [543:0] data_q[$];
  int           loader_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int m_burst  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic chkw(input string name, input logic [543:0] got, input logic [543:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  task automatic fail_evt(input string name);
    n_checks++;
    $display("FAIL %s got=event exp=none (cycle %0d)", name, cyc);
  endtask

  function automatic logic [543:0] rand_pkt();
    logic [543:0] p;
    for (int i = 0; i < 17; i++) p[i*32 +: 32] = $urandom();
    return p;
  endfunction

  // Reference model: queues up n_hs handshake and n_data data packets at once,
  // orders them by the arbitration rule and records what the monitor must see.
  // tgt: bit_en count after which the loader completes (0 = never, -1 = random).
  task automatic add_round(input int n_hs, input int n_data, input int tgt);
    logic [543:0] hl[$];
    logic [543:0] dl[$];
    logic [543:0] p;
    exp_t         g;
    exp_t         d;
    bit           pick_data;
    int           n;
    for (int i = 0; i < n_hs; i++) begin
      p = rand_pkt();
      hl.push_back(p);
    end
    for (int i = 0; i < n_data; i++) begin
      p = rand_pkt();
      dl.push_back(p);
    end
    while (hl.size() != 0 || dl.size() != 0) begin
      pick_data = (dl.size() != 0) && (hl.size() == 0 || m_burst == int'(HSMAX));
      if (pick_data) begin
        p = dl.pop_front();
        m_burst = 0;
      end else begin
        p = hl.pop_front();
        if (m_burst < int'(HSMAX)) m_burst++;
      end
      n = (tgt < 0) ? int'($urandom_range(25, 3)) : tgt;
      loader_q.push_back(n);
      g = '{is_done: 1'b0, is_data: pick_data, pkt: p, err: 1'b0, cnt: 0};
      if (n != 0 && n <= int'(TMO)) d = '{is_done: 1'b1, is_data: pick_data, pkt: '0, err: 1'b0, cnt: n};
      else d = '{is_done: 1'b1, is_data: pick_data, pkt: '0, err: 1'b1, cnt: int'(TMO)};
      exp_q.push_back(g);
      exp_q.push_back(d);
    end
    // Requester queues are filled in arrival order, independent of the model's ordering.
    for (int i = 0; i < n_hs; i++) begin
      p = rand_pkt();
      hs_q.push_back(p);
    end
    for (int i = 0; i < n_data; i++) begin
      p = rand_pkt();
      data_q.push_back(p);
    end
  endtask

  // The model above drew its own packets; realign the requester queues to them
  // by rebuilding them from the grant expectations in per-source order.
  task automatic sync_requesters();
    hs_q.delete();
    data_q.delete();
    foreach (exp_q[i]) begin
      if (!exp_q[i].is_done) begin
        if (exp_q[i].is_data) data_q.push_back(exp_q[i].pkt);
        else hs_q.push_back(exp_q[i].pkt);
      end
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !busy && hs_q.size() == 0 && data_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      $display("FAIL %s got=still_busy exp=idle within %0d cycles", name, budget);
      n_checks++;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_grant"}, 32'({grant_hs, grant_data}), 0);
    chk({tag, "_done"}, 32'({done_hs, done_data}), 0);
    chk({tag, "_tx_err"}, 32'(tx_err), 0);
    chk({tag, "_copy"}, 32'(copy_signal), 0);
    chk({tag, "_plc"}, 32'(packet_load_complete_TX), 0);
    chk({tag, "_bit_en"}, 32'(bit_en_TX), 0);
    chk({tag, "_pcnt"}, 32'(packet_counter), 0);
    chkw({tag, "_packet_TX"}, packet_TX, '0);
  endtask

  // Requesters: each holds its request while it has packets queued and
  // retires the head packet on its done pulse.
  initial begin
    req_hs   = 1'b0;
    req_data = 1'b0;
    pkt_hs   = '0;
    pkt_data = '0;
    forever begin
      @(negedge clk);
      if (done_hs && hs_q.size() != 0) void'(hs_q.pop_front());
      if (done_data && data_q.size() != 0) void'(data_q.pop_front());
      req_hs   = (hs_q.size() != 0);
      pkt_hs   = (hs_q.size() != 0) ? hs_q[0] : '0;
      req_data = (data_q.size() != 0);
      pkt_data = (data_q.size() != 0) ? data_q[0] : '0;
    end
  end

  // Loader model: restarts on each copy and raises complete_TX after its target
  // number of bit strobes; the flag then stays high until the next copy.
  initial begin
    int ld_tgt;
    int ld_cnt;
    complete_TX = 1'b0;
    ld_tgt = 0;
    ld_cnt = 0;
    forever begin
      @(negedge clk);
      if (copy_signal) begin
        ld_tgt = (loader_q.size() != 0) ? loader_q.pop_front() : 0;
        ld_cnt = 0;
        complete_TX = 1'b0;
      end else if (bit_en_TX) begin
        ld_cnt++;
        if (ld_tgt != 0 && ld_cnt == ld_tgt) complete_TX = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a grant or done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (grant_hs || grant_data) begin
        if (exp_q.size() == 0 || exp_q[0].is_done) fail_evt("unexpected_grant");
        else begin
          e = exp_q.pop_front();
          chk("grant_owner", 32'(grant_data), 32'(e.is_data));
          chk("grant_both", 32'(grant_hs & grant_data), 0);
          chkw("packet_TX", packet_TX, e.pkt);
          chk("copy_at_grant", 32'(copy_signal), 1);
        end
      end
      if (done_hs || done_data) begin
        if (exp_q.size() == 0 || !exp_q[0].is_done) fail_evt("unexpected_done");
        else begin
          e = exp_q.pop_front();
          chk("done_owner", 32'(done_data), 32'(e.is_data));
          chk("done_both", 32'(done_hs & done_data), 0);
          chk("tx_err", 32'(tx_err), 32'(e.err));
          chk("done_pcnt", 32'(packet_counter), 32'(e.cnt));
        end
      end else if (tx_err) begin
        fail_evt("tx_err_without_done");
      end
    end
  end

  initial begin
    int t_req, t_g, t_b, t_d, t_i;
    int a, b;
    bit seen;

    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    n_rst = 1'b1;
    m_burst = 0;

    // Single data packet, completion after 20 bits: latency profile.
    add_round(0, 1, 20);
    sync_requesters();
    t_req = -1; t_g = -1; t_b = -1; t_d = -1; t_i = -1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      #1;
      if (req_data && t_req < 0) t_req = cyc;
      if (grant_data && t_g < 0) t_g = cyc;
      if (bit_en_TX && t_b < 0) t_b = cyc;
      if (done_data && t_d < 0) t_d = cyc;
      if (t_d >= 0 && !busy) begin
        t_i = cyc;
        break;
      end
    end
    chk("lat_grant", 32'(t_g - t_req), 1);
    chk("lat_first_bit_en", 32'(t_b - t_g), 32'(CPB + 1));
    chk("lat_done", 32'(t_d - t_g), 32'(2 + CPB * 20));
    chk("lat_gap", 32'(t_i - t_d), 32'(GAPB * CPB));
    wait_idle(200, "wait_lat");

    // Simultaneous requests: hs then data.
    add_round(1, 1, -1);
    sync_requesters();
    wait_idle(2000, "wait_both");

    // Both held continuously: burst-limited interleave.
    add_round(3, 3, -1);
    sync_requesters();
    wait_idle(4000, "wait_burst");

    // Loader never completes: timeout abort.
    add_round(0, 1, 0);
    sync_requesters();
    seen = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      #1;
      if (done_data) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      $display("FAIL abort_done got=none exp=done_data within 6000 cycles");
      n_checks++;
    end
    @(negedge clk);
    #1;
    chk("abort_plc_low", 32'(packet_load_complete_TX), 0);
    wait_idle(200, "wait_abort");
    add_round(1, 0, -1);
    sync_requesters();
    wait_idle(1000, "wait_after_abort");

    // Reset mid-SHIFT at packet_counter == 7.
    add_round(1, 0, 0);
    sync_requesters();
    seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      #1;
      if (packet_counter == 10'd7) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      $display("FAIL reset_pcnt7 got=none exp=packet_counter 7 within 500 cycles");
      n_checks++;
    end
    n_rst = 1'b0;
    exp_q.delete();
    hs_q.delete();
    data_q.delete();
    loader_q.delete();
    m_burst = 0;
    @(negedge clk);
    #1;
    check_zero("midrst");
    n_rst = 1'b1;
    add_round(1, 0, -1);
    sync_requesters();
    wait_idle(1000, "wait_after_reset");

    // Completion coincides with the timeout count: normal end, no tx_err.
    add_round(0, 1, int'(TMO));
    sync_requesters();
    wait_idle(6000, "wait_tie");

    // Random mixes.
    for (int r = 0; r < 8; r++) begin
      a = int'($urandom_range(2, 0));
      b = int'($urandom_range(2, 0));
      if (a + b == 0) a = 1;
      add_round(a, b, -1);
      sync_requesters();
      wait_idle(3000, "wait_random");
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
